cpu_clock_gen: RTL and testbench
================================

Name: cpu_clock_gen

Overview:
- Divides the single master clock to produce the 6502 phase-2 clock `Phi2`.
- Also produces a one-master-cycle enable pulse, `cpu_clken`, aligned to the end of each CPU cycle.
- Sits between the board master clock and the CPU core. The CPU is clocked by `Phi2`; master-clock-domain logic (ROM, video, bus muxing) uses `cpu_clken` to advance in lockstep with the CPU.

Parameters:
- DIV, 12, master clocks per CPU cycle.
  - Integer, must be ≥ 2.
  - DIV < 2 is an elaboration error.
- Derived, not overridable:
  - HIGH = floor(DIV/2): `Phi2` high time in master cycles.
  - LOW = DIV − HIGH: `Phi2` low time.

Ports:
- clk  input  1  master clock, all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Phi2  output  1  CPU phase-2 clock, registered, period DIV clk cycles.
- cpu_clken  output  1  registered single-clk-cycle enable pulse, once per CPU cycle.

Behaviour:
- Interface: one clock (`clk`), rising-edge only. Reset `rst_n` is asynchronous and active-low.
- While `rst_n` = 0, all outputs and state are forced immediately, independent of `clk`:
  - internal counter cnt = 0
  - `Phi2` = 0
  - `cpu_clken` = 0
- Counter:
  - cnt is ceil(log2(DIV)) bits wide.
  - Each rising `clk` edge with `rst_n` = 1: cnt ← (cnt == DIV−1) ? 0 : cnt+1.
  - Wrap from DIV−1 to 0 with no gap. The sequence 0..DIV−1 repeats forever.
- Phi2 (registered, updated on each rising `clk` edge):
  - If cnt == LOW−1: `Phi2` ← 1.
  - Else if cnt == DIV−1: `Phi2` ← 0.
  - Otherwise `Phi2` holds.
  - Result: `Phi2` is low for LOW cycles, then high for HIGH cycles.
  - For odd DIV, the low phase is the longer one (e.g. DIV=5 gives 3 low, 2 high).
- cpu_clken (registered, recomputed every rising `clk` edge):
  - `cpu_clken` ← (cnt == DIV−2).
  - It is therefore high during exactly the last `clk` cycle of each `Phi2`-high phase.
  - The `clk` edge that samples `cpu_clken` = 1 is the same edge on which `Phi2` falls.
  - DIV=2 special case: `Phi2` and `cpu_clken` both rise and fall together, 1 cycle high and 1 low.
- Reset release:
  - The first `Phi2` rise occurs on the LOW-th rising `clk` edge after `rst_n` deasserts.
  - The first `cpu_clken` pulse starts on the (DIV−1)-th rising edge.
  - No runt pulses: the first `Phi2` high phase is a full HIGH cycles.
- Reset mid-operation:
  - Asserting `rst_n` at any point, including mid-`Phi2`-high or during a `cpu_clken` pulse, immediately drops both outputs to 0 and clears cnt.
  - On release, the sequence restarts exactly as after power-up.
- Gating: no gated clocks inside the block. `Phi2` comes straight from a flop.
- Duty and frequency depend only on DIV. No runtime inputs change them.

Test Plan:
- Reset values, DIV=12:
  - Hold `rst_n` = 0 for 20 clks → `Phi2` = 0 and `cpu_clken` = 0 throughout.
  - Drive `rst_n` low asynchronously between clk edges → outputs go to 0 without waiting for a clk edge.
- Period and duty, DIV=12:
  - After release, `Phi2` rises on clk edge 6 and falls on edge 12.
  - Period is 12 clks, 6 high / 6 low, checked over ≥ 10 CPU cycles.
- Enable alignment, DIV=12:
  - `cpu_clken` is high on edges 11→12 only, 1 clk wide, every 12 clks.
  - Every sampled `cpu_clken` = 1 edge coincides with a `Phi2` falling edge.
  - `cpu_clken` is never high while `Phi2` = 0.
- Reset mid-cycle:
  - Assert `rst_n` = 0 during the 3rd clk of a `Phi2`-high phase, hold 4 clks, release.
  - Required: outputs 0 immediately; next `Phi2` rise on the 6th edge after release.
- Parameter DIV=2:
  - `Phi2` toggles every clk edge (1 high / 1 low).
  - `cpu_clken` is identical to `Phi2`.
- Parameter DIV=5:
  - `Phi2` 3 low / 2 high, period 5.
  - `cpu_clken` high only in the 2nd `Phi2`-high cycle.
  - First `Phi2` rise on edge 3 after release.

Source files
------------

// File: rtl/cpu_clock_gen.sv
// cpu_clock_gen
//   Divides the master clock by DIV to produce the 6502 phase-2 clock and a
//   one-master-cycle enable aligned to the end of each CPU cycle, so that
//   master-clock-domain logic can advance in lockstep with the CPU.
//
// Parameters
//   DIV        master clocks per CPU cycle (>= 2)
//
// Ports
//   clk        in   master clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   Phi2       out  CPU phase-2 clock: LOW cycles low, then HIGH cycles high
//   cpu_clken  out  single-clk pulse during the last clk of each Phi2-high phase
module cpu_clock_gen #(
  parameter int unsigned DIV = 12
) (
  input  logic clk,
  input  logic rst_n,
  output logic Phi2,
  output logic cpu_clken
);

  localparam int unsigned HIGH  = DIV / 2;
  localparam int unsigned LOW   = DIV - HIGH;
  localparam int unsigned CNT_W = (DIV < 2) ? 1 : $clog2(DIV);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_RISE  = CNT_W'(LOW - 1);
  localparam logic [CNT_W-1:0] CNT_CLKEN = CNT_W'(DIV - 2);

  if (DIV < 2) begin : g_bad_div
    $error("cpu_clock_gen: DIV must be >= 2");
  end

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      Phi2      <= 1'b0;
      cpu_clken <= 1'b0;
    end else begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);

      // Rise test comes first: for DIV=2 the rise and fall counts are 0 and 1,
      // so they never collide, but ordering keeps the rise authoritative.
      if (cnt == CNT_RISE) begin
        Phi2 <= 1'b1;
      end else if (cnt == CNT_LAST) begin
        Phi2 <= 1'b0;
      end

      // Registered one count early so the pulse lands on the final
      // Phi2-high clk and is sampled on the edge where Phi2 falls.
      cpu_clken <= (cnt == CNT_CLKEN);
    end
  end

endmodule

// File: tb/tb_cpu_clock_gen.sv
module tb_cpu_clock_gen;

  logic clk;
  logic rst_n;
  logic phi2_12, clken_12;
  logic phi2_5,  clken_5;
  logic phi2_2,  clken_2;

  int unsigned tests;
  int unsigned fails;
  // rising clk edges seen with reset released since the last reset
  int unsigned k;

  cpu_clock_gen #(.DIV(12)) u_div12 (
    .clk       (clk),
    .rst_n     (rst_n),
    .Phi2      (phi2_12),
    .cpu_clken (clken_12)
  );

  cpu_clock_gen #(.DIV(5)) u_div5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .Phi2      (phi2_5),
    .cpu_clken (clken_5)
  );

  cpu_clock_gen #(.DIV(2)) u_div2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .Phi2      (phi2_2),
    .cpu_clken (clken_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // After edge k: Phi2 is high in the last HIGH = div/2 slots of each
  // div-long cycle; the enable marks the very last slot.
  function automatic logic exp_phi2(int unsigned div, int unsigned edges);
    return ((edges % div) >= (div - div / 2)) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic exp_clken(int unsigned div, int unsigned edges);
    return (edges != 0 && (edges % div) == div - 1) ? 1'b1 : 1'b0;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("phi2_div12",  phi2_12,  exp_phi2(12, k));
    chk("clken_div12", clken_12, exp_clken(12, k));
    chk("phi2_div5",   phi2_5,   exp_phi2(5, k));
    chk("clken_div5",  clken_5,  exp_clken(5, k));
    chk("phi2_div2",   phi2_2,   exp_phi2(2, k));
    chk("clken_div2",  clken_2,  exp_clken(2, k));
  endtask

  // one clk edge, then sample 1 ns later
  task automatic step();
    @(posedge clk);
    if (rst_n) k++;
    #1;
    check_all();
  endtask

  // assert reset between edges, verify outputs drop before any edge
  task automatic async_reset(input int unsigned hold);
    #($urandom_range(1, 6));
    rst_n = 1'b0;
    k = 0;
    #1;
    check_all();
    repeat (hold) step();
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    k     = 0;
    rst_n = 1'b0;

    // held reset
    repeat (20) step();

    // release between edges, run well over 10 CPU cycles of DIV=12
    #3;
    rst_n = 1'b1;
    repeat (130) step();

    // reach the 3rd clk of a DIV=12 Phi2-high phase, bounded search
    begin
      int unsigned budget;
      budget = 0;
      while ((k % 12) != 8 && budget < 24) begin
        step();
        budget++;
      end
      chk("reach_mid_high", ((k % 12) == 8) ? 1'b1 : 1'b0, 1'b1);
      chk("mid_high_phi2", phi2_12, 1'b1);
    end
    async_reset(4);
    repeat (30) step();

    // randomized run lengths and reset pulses
    for (int unsigned i = 0; i < 25; i++) begin
      repeat ($urandom_range(1, 40)) step();
      async_reset($urandom_range(1, 5));
    end
    repeat (40) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
